// File: rtl/d_flip_flop_reg_pkg.sv
// d_flip_flop_reg_pkg: shared datapath word width and word type for register blocks
package d_flip_flop_reg_pkg;
   localparam int DEFAULT_WIDTH = 32;
   typedef logic [DEFAULT_WIDTH-1:0] word_t;
endpackage

// File: rtl/d_flip_flop_reg_if.sv
// d_flip_flop_reg_if: control/data bundle for d_flip_flop_reg
//   en       load enable (pipeline advances when high)
//   clr      synchronous clear to the register's reset value
//   data_in  word captured into the first stage
//   data_out word held in the last stage
interface d_flip_flop_reg_if
   import d_flip_flop_reg_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             en;
   logic             clr;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   modport master (output en, clr, data_in, input data_out);
   modport slave (input en, clr, data_in, output data_out);
endinterface

// File: rtl/d_flip_flop_reg_stage.sv
// d_flip_flop_stage: one WIDTH-bit register with async reset, sync clear and load enable
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset to RESET_VALUE
//   en     load d when high, hold otherwise
//   clr    load RESET_VALUE on the next edge, overriding en
//   d, q   data in / registered data out
module d_flip_flop_stage
   import d_flip_flop_reg_pkg::*;
#(
   parameter int               WIDTH       = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= RESET_VALUE;
      else if (clr) q <= RESET_VALUE;
      else if (en) q <= d;
endmodule

// File: rtl/d_flip_flop_reg.sv
// d_flip_flop_reg: DEPTH-stage WIDTH-bit register pipeline with enable and sync clear
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; every stage goes to RESET_VALUE
//   bus    slave side of d_flip_flop_reg_if (en, clr, data_in in; data_out out)
// data_out is taken straight from the last stage's flop, so there is no
// combinational path from data_in.
module d_flip_flop_reg
   import d_flip_flop_reg_pkg::*;
#(
   parameter int               WIDTH       = DEFAULT_WIDTH,
   parameter int               DEPTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   d_flip_flop_reg_if.slave  bus
);
   if (DEPTH < 1) begin : g_depth_check
      $error("d_flip_flop_reg: DEPTH must be >= 1");
   end
   // pipe[0] is the input word, pipe[i+1] is the output of stage i
   logic [WIDTH-1:0] pipe [DEPTH+1];
   assign pipe[0] = bus.data_in;
   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      d_flip_flop_stage #(
         .WIDTH       (WIDTH),
         .RESET_VALUE (RESET_VALUE)
      ) u_stage (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (bus.en),
         .clr   (bus.clr),
         .d     (pipe[i]),
         .q     (pipe[i+1])
      );
   end
   assign bus.data_out = pipe[DEPTH];
endmodule

// File: tb/tb_d_flip_flop_reg.sv
// tb_d_flip_flop_reg: checks a default register and a DEPTH=3, RESET_VALUE=7 pipeline against a queue model
module tb_d_flip_flop_reg;
   import d_flip_flop_reg_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int vectors = 0;
   int miscompares = 0;
   word_t qa[$];
   word_t qb[$];
   always #5 clk = ~clk;
   d_flip_flop_reg_if #(.WIDTH(32)) ifa ();
   d_flip_flop_reg_if #(.WIDTH(32)) ifb ();
   d_flip_flop_reg dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifa.slave)
   );
   d_flip_flop_reg #(
      .WIDTH       (32),
      .DEPTH       (3),
      .RESET_VALUE (32'd7)
   ) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifb.slave)
   );
   task automatic chk(input string tag, input word_t obs, input word_t exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   // Model: a queue of the last DEPTH enabled inputs; the oldest entry is the output.
   task automatic model_reset();
      qa.delete();
      qa.push_back(32'd0);
      qb.delete();
      repeat (3) qb.push_back(32'd7);
   endtask
   task automatic drive(input logic e, input logic c, input word_t d);
      ifa.en = e;
      ifa.clr = c;
      ifa.data_in = d;
      ifb.en = e;
      ifb.clr = c;
      ifb.data_in = d;
   endtask
   task automatic step(input logic e, input logic c, input word_t d);
      drive(e, c, d);
      @(posedge clk);
      if (c) model_reset();
      else if (e) begin
         qa.push_back(d);
         void'(qa.pop_front());
         qb.push_back(d);
         void'(qb.pop_front());
      end
      @(negedge clk);
      chk("model_a", ifa.data_out, qa[0]);
      chk("model_b", ifb.data_out, qb[0]);
   endtask
   task automatic async_reset(input int unsigned dly);
      #(dly);
      rst_n = 1'b0;
      #1;
      chk("async_rst_a", ifa.data_out, 32'd0);
      chk("async_rst_b", ifb.data_out, 32'd7);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   initial begin
      model_reset();
      drive(1'b1, 1'b0, 32'd10);
      #12;
      chk("in_reset_a", ifa.data_out, 32'd0);
      chk("in_reset_b", ifb.data_out, 32'd7);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b0, 32'd10);
      chk("first_load", ifa.data_out, 32'd10);
      step(1'b1, 1'b0, 32'd10);
      chk("steady", ifa.data_out, 32'd10);
      step(1'b1, 1'b0, 32'd20);
      chk("seq20", ifa.data_out, 32'd20);
      #2;
      ifa.data_in = 32'd99;
      ifb.data_in = 32'd99;
      #1;
      chk("mid_cycle", ifa.data_out, 32'd20);
      step(1'b1, 1'b0, 32'd30);
      chk("seq30", ifa.data_out, 32'd30);
      step(1'b1, 1'b0, 32'hDEADBEEF);
      chk("load_deadbeef", ifa.data_out, 32'hDEADBEEF);
      repeat (3) begin
         step(1'b0, 1'b0, 32'h12345678);
         chk("hold", ifa.data_out, 32'hDEADBEEF);
      end
      step(1'b1, 1'b0, 32'h12345678);
      chk("resume", ifa.data_out, 32'h12345678);
      step(1'b1, 1'b0, 32'hFFFFFFFF);
      chk("load_ones", ifa.data_out, 32'hFFFFFFFF);
      step(1'b1, 1'b1, 32'h0000ABCD);
      chk("clr_wins_a", ifa.data_out, 32'd0);
      chk("clr_wins_b", ifb.data_out, 32'd7);
      step(1'b1, 1'b0, 32'h00001234);
      chk("after_clr", ifa.data_out, 32'h00001234);
      step(1'b1, 1'b0, 32'h55AA55AA);
      chk("load_55aa", ifa.data_out, 32'h55AA55AA);
      async_reset(2);
      step(1'b1, 1'b0, 32'd1);
      chk("deep_e1", ifb.data_out, 32'd7);
      step(1'b1, 1'b0, 32'd2);
      chk("deep_e2", ifb.data_out, 32'd7);
      step(1'b1, 1'b0, 32'd3);
      chk("deep_e3", ifb.data_out, 32'd1);
      step(1'b1, 1'b0, 32'd4);
      chk("deep_e4", ifb.data_out, 32'd2);
      step(1'b1, 1'b0, 32'd5);
      chk("deep_e5", ifb.data_out, 32'd3);
      step(1'b1, 1'b0, 32'd6);
      chk("deep_e6", ifb.data_out, 32'd4);
      for (int i = 0; i < 400; i++) begin
         int unsigned r;
         r = $urandom_range(0, 24);
         if (r == 0) async_reset($urandom_range(1, 4));
         else step(r >= 7, r == 1, $urandom());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
